// File: rtl/sram_access_controller_if.sv
// 68k-side strobes and SRAM control lines of the SRAM access controller.
// slave: the controller; master: the bus/CPU side that drives strobes and observes enables.
interface sram_access_controller_if;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic RW;
  logic SRamSelect_H;
  logic Block0_H;
  logic Block1_H;
  logic Block2_H;
  logic Block3_H;
  logic SRam_CE0_L;
  logic SRam_CE1_L;
  logic SRam_CE2_L;
  logic SRam_CE3_L;
  logic SRam_OE_L;
  logic SRam_WE_L;
  logic SRam_UB_L;
  logic SRam_LB_L;
  logic Dtack_L;

  modport slave (
    input  AS_L, UDS_L, LDS_L, RW, SRamSelect_H,
    input  Block0_H, Block1_H, Block2_H, Block3_H,
    output SRam_CE0_L, SRam_CE1_L, SRam_CE2_L, SRam_CE3_L,
    output SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L
  );

  modport master (
    output AS_L, UDS_L, LDS_L, RW, SRamSelect_H,
    output Block0_H, Block1_H, Block2_H, Block3_H,
    input  SRam_CE0_L, SRam_CE1_L, SRam_CE2_L, SRam_CE3_L,
    input  SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L
  );
endinterface

// File: rtl/sram_access_controller.sv
// 68k-to-SRAM access controller: wait-stated chip enables and Dtack generation.
// Optional macro SRAM_WRITE_RECOVERY_EN adds a one-clock recovery state after writes.
module sram_access_controller #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                        Clock,
  input  logic                        Reset_L,
  sram_access_controller_if.slave     bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StAck     = 2'd2
`ifdef SRAM_WRITE_RECOVERY_EN
    , StRecover = 2'd3
`endif
  } state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [1:0] blk_q;
  logic       rw_q;
  logic       uds_q;
  logic       lds_q;

  logic [3:0] ce_l_q;
  logic       oe_l_q;
  logic       we_l_q;
  logic       ub_l_q;
  logic       lb_l_q;
  logic       dtack_l_q;

  logic [1:0] blk_sel;
  logic       any_blk;
  logic       start;

  function automatic logic [3:0] ce_decode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered block wins when the decoder asserts several.
  always_comb begin
    blk_sel = 2'd0;
    if (bus.Block0_H)      blk_sel = 2'd0;
    else if (bus.Block1_H) blk_sel = 2'd1;
    else if (bus.Block2_H) blk_sel = 2'd2;
    else if (bus.Block3_H) blk_sel = 2'd3;
  end

  assign any_blk = bus.Block0_H | bus.Block1_H | bus.Block2_H | bus.Block3_H;
  assign start   = !bus.AS_L && bus.SRamSelect_H && any_blk && (!bus.UDS_L || !bus.LDS_L);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      blk_q     <= 2'd0;
      rw_q      <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      ce_l_q    <= 4'hF;
      oe_l_q    <= 1'b1;
      we_l_q    <= 1'b1;
      ub_l_q    <= 1'b1;
      lb_l_q    <= 1'b1;
      dtack_l_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAccess;
            cnt_q   <= 3'(WAIT_STATES);
            blk_q   <= blk_sel;
            rw_q    <= bus.RW;
            uds_q   <= bus.UDS_L;
            lds_q   <= bus.LDS_L;
            ce_l_q  <= ce_decode(blk_sel);
            oe_l_q  <= ~bus.RW;
            we_l_q  <= bus.RW;
            ub_l_q  <= bus.UDS_L;
            lb_l_q  <= bus.LDS_L;
          end
        end
        StAccess: begin
          if (bus.AS_L) begin
            // Aborted cycle: release everything, Dtack never asserts.
            state_q <= StIdle;
            ce_l_q  <= 4'hF;
            oe_l_q  <= 1'b1;
            we_l_q  <= 1'b1;
            ub_l_q  <= 1'b1;
            lb_l_q  <= 1'b1;
          end else if (cnt_q == 3'd0) begin
            // WE rises while CE/OE/byte lanes stay put to give write data hold.
            state_q   <= StAck;
            ce_l_q    <= ce_decode(blk_q);
            oe_l_q    <= ~rw_q;
            we_l_q    <= 1'b1;
            ub_l_q    <= uds_q;
            lb_l_q    <= lds_q;
            dtack_l_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StAck: begin
          if (bus.AS_L) begin
`ifdef SRAM_WRITE_RECOVERY_EN
            state_q <= rw_q ? StIdle : StRecover;
`else
            state_q <= StIdle;
`endif
            ce_l_q    <= 4'hF;
            oe_l_q    <= 1'b1;
            we_l_q    <= 1'b1;
            ub_l_q    <= 1'b1;
            lb_l_q    <= 1'b1;
            dtack_l_q <= 1'b1;
          end
        end
`ifdef SRAM_WRITE_RECOVERY_EN
        StRecover: state_q <= StIdle;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.SRam_CE0_L = ce_l_q[0];
  assign bus.SRam_CE1_L = ce_l_q[1];
  assign bus.SRam_CE2_L = ce_l_q[2];
  assign bus.SRam_CE3_L = ce_l_q[3];
  assign bus.SRam_OE_L  = oe_l_q;
  assign bus.SRam_WE_L  = we_l_q;
  assign bus.SRam_UB_L  = ub_l_q;
  assign bus.SRam_LB_L  = lb_l_q;
  assign bus.Dtack_L    = dtack_l_q;

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed plus randomized bench for sram_access_controller against a cycle-index reference model.
module tb_sram_access_controller;
  localparam int WS = 2;

  logic Clock = 1'b0;
  logic Reset_L;
  int   checks = 0;
  int   errors = 0;
  bit   recover_pending = 1'b0;

  sram_access_controller_if bus();

  sram_access_controller #(.WAIT_STATES(WS)) dut (
    .Clock   (Clock),
    .Reset_L (Reset_L),
    .bus     (bus.slave)
  );

  always #5 Clock = ~Clock;

  // {CE3, CE2, CE1, CE0, OE, WE, UB, LB, Dtack}
  logic [8:0] obs;
  assign obs = {bus.SRam_CE3_L, bus.SRam_CE2_L, bus.SRam_CE1_L, bus.SRam_CE0_L,
                bus.SRam_OE_L, bus.SRam_WE_L, bus.SRam_UB_L, bus.SRam_LB_L, bus.Dtack_L};

  localparam logic [8:0] Inactive = 9'h1FF;

  // Expected outputs k edges after the entry edge of an ongoing access.
  function automatic logic [8:0] model(input int blk, input bit rw, input bit uds,
                                       input bit lds, input int k);
    logic [3:0] ce;
    ce = 4'hF;
    ce[blk] = 1'b0;
    return {ce, (rw ? 1'b0 : 1'b1), ((!rw && k <= WS) ? 1'b0 : 1'b1), uds, lds,
            ((k > WS) ? 1'b0 : 1'b1)};
  endfunction

  function automatic int lowest(input logic [3:0] mask);
    int b = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) b = i;
    return b;
  endfunction

  task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit as_l, input bit sel, input logic [3:0] mask, input bit rw,
                       input bit uds, input bit lds);
    bus.AS_L = as_l;
    bus.SRamSelect_H = sel;
    {bus.Block3_H, bus.Block2_H, bus.Block1_H, bus.Block0_H} = mask;
    bus.RW = rw;
    bus.UDS_L = uds;
    bus.LDS_L = lds;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle", obs, Inactive);
    end
    recover_pending = 1'b0;
  endtask

  // abort_k > 0: AS_L sampled high at edge abort_k (1..WS+1) while still waiting.
  task automatic run_access(input logic [3:0] mask, input bit rw, input bit uds, input bit lds,
                            input int abort_k, input int hold);
    int blk;
    int last;
    if (uds && lds) lds = 1'b0;
    blk = lowest(mask);
    drive(1'b0, 1'b1, mask, rw, uds, lds);
    tick();
    if (recover_pending) begin
      check("recover_gap", obs, Inactive);
      recover_pending = 1'b0;
      tick();
    end
    check("entry", obs, model(blk, rw, uds, lds, 0));
    // Later input changes must be ignored while AS_L stays low.
    drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    last = (abort_k > 0) ? abort_k : WS + 2 + hold;
    for (int k = 1; k <= last; k++) begin
      if (k == last) drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
      tick();
      if (k == last) check((abort_k > 0) ? "abort_exit" : "ack_exit", obs, Inactive);
      else           check("access", obs, model(blk, rw, uds, lds, k));
    end
`ifdef SRAM_WRITE_RECOVERY_EN
    recover_pending = (abort_k <= 0) && !rw;
`else
    recover_pending = 1'b0;
`endif
  endtask

  initial begin
    Reset_L = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("reset", obs, Inactive);
    #4 Reset_L = 1'b1;

    // Read from block 2, both lanes.
    run_access(4'b0100, 1'b1, 1'b0, 1'b0, 0, 2);
    idle_cycles(1);
    // Byte write to block 1, lower lane only.
    run_access(4'b0010, 1'b0, 1'b1, 1'b0, 0, 1);
    idle_cycles(2);
    // Blocks 0 and 3 together: block 0 wins.
    run_access(4'b1001, 1'b1, 1'b0, 1'b0, 0, 0);
    idle_cycles(1);
    // Abort after one access cycle, then confirm no CE pulse follows.
    run_access(4'b0100, 1'b1, 1'b0, 1'b1, 1, 0);
    idle_cycles(3);

    // Non-qualifying strobes must not start an access.
    drive(1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    check("no_select", obs, Inactive);
    drive(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    check("no_block", obs, Inactive);
    drive(1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    check("no_strobe", obs, Inactive);
    idle_cycles(1);

    // Reset pulse while in ACK, then a fresh access with full latency.
    drive(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_entry", obs, model(3, 1'b0, 1'b0, 1'b0, 0));
    for (int k = 1; k <= WS + 1; k++) begin
      tick();
      check("rst_access", obs, model(3, 1'b0, 1'b0, 1'b0, k));
    end
    #3 Reset_L = 1'b0;
    #1 check("rst_async", obs, Inactive);
    #2 Reset_L = 1'b1;
    recover_pending = 1'b0;
    run_access(4'b1000, 1'b1, 1'b0, 1'b0, 0, 0);

    // Write immediately followed by a read strobe.
    idle_cycles(1);
    run_access(4'b0001, 1'b0, 1'b0, 1'b0, 0, 0);
    run_access(4'b0010, 1'b1, 1'b0, 1'b0, 0, 1);
    idle_cycles(1);

    for (int t = 0; t < 30; t++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WS + 1) : 0;
      run_access(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
